// File: rtl/tail_light_if.sv
// Lamp-cluster control bundle: driver requests in, lamp drives out.
// Optional brake input appears when TAIL_LIGHT_BRAKE_EN is defined.
interface tail_light_if;
   logic       left;
   logic       right;
   logic       haz;
`ifdef TAIL_LIGHT_BRAKE_EN
   logic       brake;
`endif
   logic [5:0] light;

`ifdef TAIL_LIGHT_BRAKE_EN
   modport master (output left, output right, output haz, output brake, input light);
   modport slave  (input left, input right, input haz, input brake, output light);
`else
   modport master (output left, output right, output haz, input light);
   modport slave  (input left, input right, input haz, output light);
`endif
endinterface

// File: rtl/tail_light.sv
// tail_light: turn-signal / hazard sequencer for a 3+3 lamp rear cluster.
// Moore FSM advanced once per tick (every DIV clocks); lamp pattern is
// decoded from the next state and registered alongside p_state so both
// change on the same edge.
// Optional feature macro: TAIL_LIGHT_BRAKE_EN (adds brake override).
// light[5:0] = {LC,LB,LA,RA,RB,RC}; LA/RA are the innermost lamps.
module tail_light #(
   parameter int DIV = 1
) (
   input  logic         clk,
   input  logic         reset,
   tail_light_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      L1   = 3'd1,
      L2   = 3'd2,
      L3   = 3'd3,
      R1   = 3'd4,
      R2   = 3'd5,
      R3   = 3'd6,
      HAZ  = 3'd7
   } state_t;

   localparam logic [5:0] PAT_OFF = 6'b000000;
   localparam logic [5:0] PAT_L1  = 6'b001000;
   localparam logic [5:0] PAT_L2  = 6'b011000;
   localparam logic [5:0] PAT_L3  = 6'b111000;
   localparam logic [5:0] PAT_R1  = 6'b000100;
   localparam logic [5:0] PAT_R2  = 6'b000110;
   localparam logic [5:0] PAT_R3  = 6'b000111;
   localparam logic [5:0] PAT_ALL = 6'b111111;

   state_t     p_state;
   state_t     n_state;
   logic [5:0] light_reg;
   logic [5:0] light_next;
   logic [5:0] light_decode;
   logic       tick;
   logic       hz;

   // Both turn requests at once are treated as a hazard request.
   assign hz = bus.haz | (bus.left & bus.right);

   // Tick generation: constant for DIV=1, otherwise a wrapping 0..DIV-1 counter.
   generate
      if (DIV <= 1) begin : g_tick_const
         assign tick = 1'b1;
      end else begin : g_tick_cnt
         localparam int CW = $clog2(DIV);
         localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
         logic [CW-1:0] cnt;

         // Free-running step counter; wraps after the tick cycle.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end

         assign tick = (cnt == CNT_LAST);
      end
   endgenerate

   // Pure Moore decode of a state to its lamp pattern.
   function automatic logic [5:0] decode(input state_t s);
      logic [5:0] p;
      p = PAT_OFF;
      case (s)
         IDLE:    p = PAT_OFF;
         L1:      p = PAT_L1;
         L2:      p = PAT_L2;
         L3:      p = PAT_L3;
         R1:      p = PAT_R1;
         R2:      p = PAT_R2;
         R3:      p = PAT_R3;
         HAZ:     p = PAT_ALL;
         default: p = PAT_OFF;
      endcase
      return p;
   endfunction

   // Next-state logic: only moves on a tick; hazard preempts any sweep.
   always_comb begin
      n_state = p_state;
      if (tick) begin
         case (p_state)
            IDLE: begin
               if (hz)             n_state = HAZ;
               else if (bus.left)  n_state = L1;
               else if (bus.right) n_state = R1;
               else                n_state = IDLE;
            end
            // A started sweep runs to completion unless a hazard arrives.
            L1:      n_state = hz ? HAZ : L2;
            L2:      n_state = hz ? HAZ : L3;
            L3:      n_state = hz ? HAZ : IDLE;
            R1:      n_state = hz ? HAZ : R2;
            R2:      n_state = hz ? HAZ : R3;
            R3:      n_state = hz ? HAZ : IDLE;
            // Held hazard alternates HAZ/IDLE, giving the flash.
            HAZ:     n_state = IDLE;
            default: n_state = IDLE;
         endcase
      end
   end

   assign light_decode = decode(n_state);

`ifdef TAIL_LIGHT_BRAKE_EN
   // Brake override: light the side that is not sweeping (both sides in IDLE).
   always_comb begin
      light_next = light_decode;
      if (bus.brake && (n_state != HAZ)) begin
         case (n_state)
            L1, L2, L3: light_next = {light_decode[5:3], 3'b111};
            R1, R2, R3: light_next = {3'b111, light_decode[2:0]};
            default:    light_next = PAT_ALL;
         endcase
      end
   end
`else
   // Without brake support the lamps are the plain state decode.
   always_comb begin
      light_next = light_decode;
   end
`endif

   // State and lamp registers update together; reset blanks the lamps at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_state   <= IDLE;
         light_reg <= PAT_OFF;
      end else begin
         p_state   <= n_state;
         light_reg <= light_next;
      end
   end

   assign bus.light = light_reg;

endmodule

// File: tb/tb_tail_light.sv
// Self-checking bench for tail_light: DIV=1 instance for sequencing and
// a DIV=4 instance for tick pacing and asynchronous reset.
`timescale 1ns/1ps
module tb_tail_light;

   typedef struct {
      logic [5:0] light;
      logic [2:0] st;
   } exp_t;

   logic clk = 1'b0;
   logic reset1;
   logic reset4;
   int   tests  = 0;
   int   failed = 0;
   exp_t sb[$];

   tail_light_if if1 ();
   tail_light_if if4 ();

   tail_light #(.DIV(1)) dut1 (.clk(clk), .reset(reset1), .bus(if1));
   tail_light #(.DIV(4)) dut4 (.clk(clk), .reset(reset4), .bus(if4));

   always #5 clk = ~clk;

`ifdef TAIL_LIGHT_BRAKE_EN
   initial begin
      if1.brake = 1'b0;
      if4.brake = 1'b0;
   end
`endif

   // Run a DIV=1 stimulus table: drive one row per clock, compare after the edge.
   task automatic test_reset;
      exp_t e;
      reset1 = 1'b1; reset4 = 1'b1;
      if1.left = 1'b1; if1.right = 1'b0; if1.haz = 1'b1;
      if4.left = 1'b1; if4.right = 1'b1; if4.haz = 1'b0;
      #2;
      tests++;
      if (if1.light !== 6'b0 || dut1.p_state !== 3'd0) begin
         failed++;
         $display("FAIL reset_async: light=%b state=%0d want light=000000 state=0", if1.light, dut1.p_state);
      end
      @(posedge clk); #1;
      tests++;
      if (if1.light !== 6'b0 || dut1.p_state !== 3'd0 || if4.light !== 6'b0) begin
         failed++;
         $display("FAIL reset_held: light1=%b state=%0d light4=%b want 000000/0/000000", if1.light, dut1.p_state, if4.light);
      end
      if1.left = 1'b0; if1.haz = 1'b0;
      if4.left = 1'b0; if4.right = 1'b0;
      reset1 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sb.push_back('{6'b000000, 3'd0});
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if (if1.light !== e.light || dut1.p_state !== e.st) begin
            failed++;
            $display("FAIL reset_release step %0d: light=%b state=%0d want light=%b state=%0d", i, if1.light, dut1.p_state, e.light, e.st);
         end
      end
      $display("[TB] reset checks done");
   endtask

   task automatic test_hazard;
      logic [2:0] in_t [3] = '{3'b111, 3'b111, 3'b000};   // {left,right,haz}
      logic [5:0] el [3]   = '{6'b111111, 6'b000000, 6'b000000};
      logic [2:0] es [3]   = '{3'd7, 3'd0, 3'd0};
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         {if1.left, if1.right, if1.haz} = in_t[i];
         sb.push_back('{el[i], es[i]});
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if (if1.light !== e.light || dut1.p_state !== e.st) begin
            failed++;
            $display("FAIL hazard step %0d: light=%b state=%0d want light=%b state=%0d", i, if1.light, dut1.p_state, e.light, e.st);
         end
      end
      $display("[TB] hazard flash checked");
   endtask

   task automatic test_left_sweep;
      logic [2:0] in_t [4] = '{3'b100, 3'b100, 3'b100, 3'b000};
      logic [5:0] el [4]   = '{6'b001000, 6'b011000, 6'b111000, 6'b000000};
      logic [2:0] es [4]   = '{3'd1, 3'd2, 3'd3, 3'd0};
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         {if1.left, if1.right, if1.haz} = in_t[i];
         sb.push_back('{el[i], es[i]});
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if (if1.light !== e.light || dut1.p_state !== e.st) begin
            failed++;
            $display("FAIL left_sweep step %0d: light=%b state=%0d want light=%b state=%0d", i, if1.light, dut1.p_state, e.light, e.st);
         end
      end
      $display("[TB] left sweep checked");
   endtask

   task automatic test_right_sweep;
      logic [2:0] in_t [6] = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b110, 3'b000};
      logic [5:0] el [6]   = '{6'b000100, 6'b000110, 6'b000111, 6'b000000, 6'b111111, 6'b000000};
      logic [2:0] es [6]   = '{3'd4, 3'd5, 3'd6, 3'd0, 3'd7, 3'd0};
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         {if1.left, if1.right, if1.haz} = in_t[i];
         sb.push_back('{el[i], es[i]});
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if (if1.light !== e.light || dut1.p_state !== e.st) begin
            failed++;
            $display("FAIL right_sweep step %0d: light=%b state=%0d want light=%b state=%0d", i, if1.light, dut1.p_state, e.light, e.st);
         end
      end
      $display("[TB] right sweep and both-sides hazard checked");
   endtask

   task automatic test_hazard_interrupt;
      logic [2:0] in_t [7] = '{3'b100, 3'b100, 3'b001, 3'b000, 3'b010, 3'b110, 3'b000};
      logic [5:0] el [7]   = '{6'b001000, 6'b011000, 6'b111111, 6'b000000, 6'b000100, 6'b111111, 6'b000000};
      logic [2:0] es [7]   = '{3'd1, 3'd2, 3'd7, 3'd0, 3'd4, 3'd7, 3'd0};
      exp_t e;
      for (int i = 0; i < 7; i++) begin
         {if1.left, if1.right, if1.haz} = in_t[i];
         sb.push_back('{el[i], es[i]});
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if (if1.light !== e.light || dut1.p_state !== e.st) begin
            failed++;
            $display("FAIL hazard_interrupt step %0d: light=%b state=%0d want light=%b state=%0d", i, if1.light, dut1.p_state, e.light, e.st);
         end
      end
      $display("[TB] hazard interrupt checked");
   endtask

   // Sweep completes after the request drops; held request passes through IDLE.
   task automatic test_back_to_back;
      logic [2:0] in_t [11] = '{3'b100, 3'b000, 3'b000, 3'b000,
                                3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
      logic [5:0] el [11]   = '{6'b001000, 6'b011000, 6'b111000, 6'b000000,
                                6'b001000, 6'b011000, 6'b111000, 6'b000000, 6'b001000, 6'b011000, 6'b111000};
      logic [2:0] es [11]   = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
      exp_t e;
      for (int i = 0; i < 11; i++) begin
         {if1.left, if1.right, if1.haz} = in_t[i];
         sb.push_back('{el[i], es[i]});
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if (if1.light !== e.light || dut1.p_state !== e.st) begin
            failed++;
            $display("FAIL back_to_back step %0d: light=%b state=%0d want light=%b state=%0d", i, if1.light, dut1.p_state, e.light, e.st);
         end
      end
      $display("[TB] back-to-back sweeps checked");
   endtask

   // DIV=4: each pattern lasts 4 clocks, off-tick pulses are ignored,
   // and reset acts without a clock edge.
   task automatic test_div4;
      logic [5:0] pat [4] = '{6'b000000, 6'b001000, 6'b011000, 6'b111000};
      exp_t e;
      int   ph;
      // Left pulse on a non-tick edge only; the machine must stay IDLE.
      if4.left = 1'b1;
      reset4 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         sb.push_back('{6'b000000, 3'd0});
         @(posedge clk); #1;
         if4.left = 1'b0;
         e = sb.pop_front();
         tests++;
         if (if4.light !== e.light || dut4.p_state !== e.st) begin
            failed++;
            $display("FAIL div4_pulse cycle %0d: light=%b state=%0d want light=%b state=%0d", k, if4.light, dut4.p_state, e.light, e.st);
         end
      end
      // Hold left until mid-L2, then pulse reset between edges.
      if4.left = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         ph = (k / 4) % 4;
         sb.push_back('{pat[ph], 3'(ph)});
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if (if4.light !== e.light || dut4.p_state !== e.st) begin
            failed++;
            $display("FAIL div4_pace cycle %0d: light=%b state=%0d want light=%b state=%0d", k, if4.light, dut4.p_state, e.light, e.st);
         end
      end
      #2 reset4 = 1'b1;
      #1;
      tests++;
      if (if4.light !== 6'b000000 || dut4.p_state !== 3'd0) begin
         failed++;
         $display("FAIL div4_async_reset: light=%b state=%0d want light=000000 state=0", if4.light, dut4.p_state);
      end
      @(posedge clk); #1;
      reset4 = 1'b0;
      // Full held-left run from a fresh counter: IDLE x3, then 4 clocks per step.
      for (int k = 1; k <= 22; k++) begin
         ph = (k / 4) % 4;
         sb.push_back('{pat[ph], 3'(ph)});
         @(posedge clk); #1;
         e = sb.pop_front();
         tests++;
         if (if4.light !== e.light || dut4.p_state !== e.st) begin
            failed++;
            $display("FAIL div4_hold cycle %0d: light=%b state=%0d want light=%b state=%0d", k, if4.light, dut4.p_state, e.light, e.st);
         end
      end
      if4.left = 1'b0;
      $display("[TB] DIV=4 pacing and async reset checked");
   endtask

   initial begin
      test_reset();
      test_hazard();
      test_left_sweep();
      test_right_sweep();
      test_hazard_interrupt();
      test_back_to_back();
      test_div4();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tail_light.md
Name: tail_light

Overview:
- Turn-signal and hazard sequencer for a three-lamp-per-side rear light cluster.
- A Moore state machine steps the left or right lamp group in a growing sweep, or flashes all six lamps for hazard.
- Sits between the driver-control inputs and the lamp drivers, on a single clock domain.

Parameters:
- DIV, 1, number of clock cycles per sequencer step (tick); must be >= 1; DIV=1 means the state machine advances on every clock.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- left  input  1  left turn request, level
- right  input  1  right turn request, level
- haz  input  1  hazard request, level
- light  output  6  lamp drives, registered; bit map {LC,LB,LA,RA,RB,RC} = light[5:0]; LA/RA are the innermost lamps

Behaviour:
- One clock and one asynchronous active-high reset (clk, reset).
- State register is named p_state, 3 bits. Encoding: IDLE=0, L1=1, L2=2, L3=3, R1=4, R2=5, R3=6, HAZ=7.
- Reset, asynchronous: p_state=IDLE, light=000000, tick counter=0.
- Tick generation:
  - Counter runs 0..DIV-1 and wraps to 0.
  - tick=1 when counter==DIV-1.
  - For DIV=1, tick is constant 1.
  - The state advances only on a rising clk edge with tick=1; otherwise it holds.
- Effective hazard: hz = haz | (left & right).
- Transitions, evaluated at a tick:
  - IDLE: hz -> HAZ; else left -> L1; else right -> R1; else stay IDLE.
  - L1 -> L2 -> L3 -> IDLE. R1 -> R2 -> R3 -> IDLE.
  - A started sweep completes even if left or right drops.
  - In any L or R state, hz=1 -> HAZ immediately; this overrides the sweep step.
  - HAZ -> IDLE unconditionally. Holding haz therefore flashes HAZ/IDLE alternately, one step each.
  - From L3 or R3 the machine always passes through IDLE (lamps off) before restarting, even if the request is still held.
- Outputs are Moore, decoded from p_state and registered together with it, so light changes on the same edge as p_state:
  - IDLE 000000
  - L1 001000, L2 011000, L3 111000
  - R1 000100, R2 000110, R3 000111
  - HAZ 111111
- Inputs are sampled only at tick edges; pulses between ticks are ignored.
- Reset asserted mid-sequence forces IDLE/000000 at once, independent of clk.
- Illegal states are impossible with a 3-bit register holding eight legal codes; a default branch returns to IDLE.

Optional Feature:
- TAIL_LIGHT_BRAKE_EN defined:
  - Adds input port brake (1 bit), placed after haz.
  - While brake=1 and p_state is not HAZ, lamps of the side not currently sweeping are forced on (111 on that side).
  - In IDLE with brake=1, light=111111.
  - State transitions are unaffected; the brake override is applied combinationally after the state decode and then registered.
- Not defined: no brake port; light is the pure state decode.

Test Plan:
- Reset: reset=1 with any inputs -> light=000000, p_state=0; release reset -> remains IDLE with all inputs 0.
- Hazard, DIV=1: haz=left=right=1 for 2 clocks, then all inputs 0 -> light 111111 then 000000, p_state 7 then 0.
- Left sweep: left=1 for 3 clocks, then 0 -> light 001000, 011000, 111000, then 000000; p_state 1,2,3,0.
- Right sweep: right=1 for 3 clocks -> 000100, 000110, 000111, then 000000. Next, left=right=1 with haz=0 -> 111111, i.e. treated as hazard.
- Hazard interrupt: start the left sweep; at L2 assert haz -> next edge light=111111; the following edge gives 000000.
- DIV=4: left held -> each lamp pattern persists exactly 4 clocks; asynchronous reset pulse mid-L2 -> immediate 000000.
